// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush bubbles,
// external hold and saturating stall/flush event counters.
module id_ex_hazard_reg #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned CTRL_W   = 12,
    parameter logic [4:0]  ZERO_REG = 5'd31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ID,
    input  logic [4:0]        Aa_ID,
    input  logic [4:0]        Ab_ID,
    input  logic              usesA_ID,
    input  logic              usesB_ID,
    input  logic [DATA_W-1:0] Da_ID,
    input  logic [DATA_W-1:0] Db_ID,
    input  logic [DATA_W-1:0] imm_ID,
    input  logic [4:0]        Rd_ID,
    input  logic              RegWrite_ID,
    input  logic              MemRead_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic              flush,
    input  logic              hold,
    output logic [4:0]        Aa_EX,
    output logic [4:0]        Ab_EX,
    output logic [4:0]        WriteRegister_EX,
    output logic [DATA_W-1:0] Da_EX,
    output logic [DATA_W-1:0] Db_EX,
    output logic [DATA_W-1:0] imm_EX,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic              RegWrite_EX,
    output logic              MemRead_EX,
    output logic              valid_EX,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              load_use,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [0:0] {StRun, StBubble} state_e;

    typedef struct packed {
        logic [4:0]        aa;
        logic [4:0]        ab;
        logic [4:0]        rd;
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
        logic              regWrite;
        logic              memRead;
        logic              valid;
    } exFields_t;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           stateQ, stateD;
    exFields_t        exQ, exD;
    exFields_t        bubbleEx, capturedEx;
    logic [CNT_W-1:0] stallCntQ, stallCntD;
    logic [CNT_W-1:0] flushCntQ, flushCntD;
    logic             loadUse;
    logic             stallReq;
    logic             hitA, hitB;

    // A load in EX whose destination is read by the ID instruction cannot be forwarded yet.
    always_comb begin
        hitA    = usesA_ID && (Aa_ID == exQ.rd);
        hitB    = usesB_ID && (Ab_ID == exQ.rd);
        loadUse = valid_ID && exQ.valid && exQ.memRead && (exQ.rd != ZERO_REG) &&
                  (hitA || hitB);
    end

    always_comb begin
        bubbleEx    = '0;
        bubbleEx.aa = ZERO_REG;
        bubbleEx.ab = ZERO_REG;
        bubbleEx.rd = ZERO_REG;

        capturedEx          = '0;
        capturedEx.aa       = Aa_ID;
        capturedEx.ab       = Ab_ID;
        capturedEx.rd       = Rd_ID;
        capturedEx.da       = Da_ID;
        capturedEx.db       = Db_ID;
        capturedEx.imm      = imm_ID;
        capturedEx.ctrl     = ctrl_ID;
        capturedEx.regWrite = RegWrite_ID;
        capturedEx.memRead  = MemRead_ID;
        capturedEx.valid    = 1'b1;
    end

    // Priority per edge: flush, then hold, then load-use, then normal capture.
    always_comb begin
        exD       = exQ;
        stateD    = stateQ;
        stallCntD = stallCntQ;
        flushCntD = flushCntQ;
        stallReq  = 1'b0;

        if (flush) begin
            exD    = bubbleEx;
            stateD = StRun;
            if (flushCntQ != '1) begin
                flushCntD = flushCntQ + CntOne;
            end
        end else if (hold) begin
            stallReq = 1'b1;
        end else if (loadUse) begin
            exD      = bubbleEx;
            stallReq = 1'b1;
            stateD   = StBubble;
            if (stallCntQ != '1) begin
                stallCntD = stallCntQ + CntOne;
            end
        end else begin
            exD    = valid_ID ? capturedEx : bubbleEx;
            stateD = StRun;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= StRun;
            exQ       <= '0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            exQ       <= exD;
            stallCntQ <= stallCntD;
            flushCntQ <= flushCntD;
        end
    end

    assign Aa_EX            = exQ.aa;
    assign Ab_EX            = exQ.ab;
    assign WriteRegister_EX = exQ.rd;
    assign Da_EX            = exQ.da;
    assign Db_EX            = exQ.db;
    assign imm_EX           = exQ.imm;
    assign ctrl_EX          = exQ.ctrl;
    assign RegWrite_EX      = exQ.regWrite;
    assign MemRead_EX       = exQ.memRead;
    assign valid_EX         = exQ.valid;
    assign stall_pc         = stallReq;
    assign stall_ifid       = stallReq;
    assign load_use         = loadUse;
    assign stall_cnt        = stallCntQ;
    assign flush_cnt        = flushCntQ;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed, table-driven bench for id_ex_hazard_reg plus hand sequences for reset
// during a bubble and counter saturation (small-counter instance alongside).
module tb_id_ex_hazard_reg;

    localparam int KB = 0;  // expect bubble
    localparam int KC = 1;  // expect capture of this vector
    localparam int KH = 2;  // expect EX unchanged

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_ID = 1'b0;
    logic [4:0]  Aa_ID = '0, Ab_ID = '0, Rd_ID = '0;
    logic        usesA_ID = 1'b0, usesB_ID = 1'b0, RegWrite_ID = 1'b0, MemRead_ID = 1'b0;
    logic        flush = 1'b0, hold = 1'b0;
    logic [63:0] Da_ID = '0, Db_ID = '0, imm_ID = '0;
    logic [11:0] ctrl_ID = '0;

    logic [4:0]  Aa_EX, Ab_EX, WriteRegister_EX;
    logic [63:0] Da_EX, Db_EX, imm_EX;
    logic [11:0] ctrl_EX;
    logic        RegWrite_EX, MemRead_EX, valid_EX, stall_pc, stall_ifid, load_use;
    logic [15:0] stall_cnt, flush_cnt;

    logic [4:0]  sAa, sAb, sWr;
    logic [63:0] sDa, sDb, sImm;
    logic [11:0] sCtrl;
    logic        sRw, sMr, sValid, sStallPc, sStallIfid, sLu;
    logic [3:0]  sStallCnt, sFlushCnt;

    always #5 clk = ~clk;

    id_ex_hazard_reg dut (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .Aa_ID(Aa_ID), .Ab_ID(Ab_ID),
        .usesA_ID(usesA_ID), .usesB_ID(usesB_ID), .Da_ID(Da_ID), .Db_ID(Db_ID),
        .imm_ID(imm_ID), .Rd_ID(Rd_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
        .ctrl_ID(ctrl_ID), .flush(flush), .hold(hold), .Aa_EX(Aa_EX), .Ab_EX(Ab_EX),
        .WriteRegister_EX(WriteRegister_EX), .Da_EX(Da_EX), .Db_EX(Db_EX), .imm_EX(imm_EX),
        .ctrl_EX(ctrl_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
        .valid_EX(valid_EX), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .load_use(load_use), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_hazard_reg #(.CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .Aa_ID(Aa_ID), .Ab_ID(Ab_ID),
        .usesA_ID(usesA_ID), .usesB_ID(usesB_ID), .Da_ID(Da_ID), .Db_ID(Db_ID),
        .imm_ID(imm_ID), .Rd_ID(Rd_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
        .ctrl_ID(ctrl_ID), .flush(flush), .hold(hold), .Aa_EX(sAa), .Ab_EX(sAb),
        .WriteRegister_EX(sWr), .Da_EX(sDa), .Db_EX(sDb), .imm_EX(sImm),
        .ctrl_EX(sCtrl), .RegWrite_EX(sRw), .MemRead_EX(sMr),
        .valid_EX(sValid), .stall_pc(sStallPc), .stall_ifid(sStallIfid),
        .load_use(sLu), .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
    );

    typedef struct {
        logic       v;
        logic [4:0] aa, ab;
        logic       ua, ub;
        logic [4:0] rd;
        logic       rw, mr, fl, ho;
        logic       expLu, expStall;
        int         kind;
        int         expStallCnt, expFlushCnt;
    } vec_t;

    vec_t vecs[21];
    int   total = 0;
    int   bad = 0;

    // Expected EX-stage contents, maintained by the bench.
    logic        eValid, eRw, eMr;
    logic [4:0]  eWr, eAa, eAb;
    logic [63:0] eDa, eDb, eImm;
    logic [11:0] eCtrl;

    function automatic vec_t mk(input logic v, input int aa, input int ab, input logic ua,
                                input logic ub, input int rd, input logic rw, input logic mr,
                                input logic fl, input logic ho, input logic lu,
                                input logic st, input int kind, input int sc, input int fc);
        vec_t r;
        r.v = v; r.aa = 5'(aa); r.ab = 5'(ab); r.ua = ua; r.ub = ub; r.rd = 5'(rd);
        r.rw = rw; r.mr = mr; r.fl = fl; r.ho = ho; r.expLu = lu; r.expStall = st;
        r.kind = kind; r.expStallCnt = sc; r.expFlushCnt = fc;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setId(input logic v, input logic [4:0] aa, input logic [4:0] ab,
                         input logic ua, input logic ub, input logic [4:0] rd,
                         input logic rw, input logic mr, input int tag);
        valid_ID = v; Aa_ID = aa; Ab_ID = ab; usesA_ID = ua; usesB_ID = ub; Rd_ID = rd;
        RegWrite_ID = rw; MemRead_ID = mr;
        Da_ID   = 64'hA000_0000_0000_0000 | 64'(tag);
        Db_ID   = 64'hB000_0000_0000_0000 | 64'(tag);
        imm_ID  = 64'hC000_0000_0000_0000 | 64'(tag);
        ctrl_ID = 12'h800 | 12'(tag);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 31, 1, 0, 2, 1, 1, 0, 0, 0, 0, KC, 0, 0);   // LDUR X2
        vecs[1]  = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 1, 1, KB, 1, 0);    // ADD X3,X2,X4
        vecs[2]  = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, KC, 1, 0);    // ADD enters EX
        vecs[3]  = mk(1, 1, 31, 1, 0, 31, 1, 1, 0, 0, 0, 0, KC, 1, 0);  // load to X31
        vecs[4]  = mk(1, 31, 31, 1, 1, 6, 1, 0, 0, 0, 0, 0, KC, 1, 0);  // reads X31
        vecs[5]  = mk(1, 1, 31, 1, 0, 5, 1, 1, 0, 0, 0, 0, KC, 1, 0);   // load X5
        vecs[6]  = mk(1, 7, 5, 1, 0, 8, 1, 0, 0, 0, 0, 0, KC, 1, 0);    // Ab=5 unused
        vecs[7]  = mk(1, 1, 31, 1, 0, 5, 1, 1, 0, 0, 0, 0, KC, 1, 0);   // load X5
        vecs[8]  = mk(1, 7, 5, 1, 1, 8, 1, 0, 0, 0, 1, 1, KB, 2, 0);    // Ab=5 used
        vecs[9]  = mk(1, 7, 5, 1, 1, 8, 1, 0, 0, 0, 0, 0, KC, 2, 0);
        vecs[10] = mk(1, 1, 31, 1, 0, 9, 1, 1, 0, 0, 0, 0, KC, 2, 0);   // load X9
        vecs[11] = mk(1, 9, 31, 1, 0, 11, 1, 0, 1, 0, 1, 0, KB, 2, 1);  // flush + load-use
        vecs[12] = mk(1, 1, 31, 1, 0, 10, 1, 1, 0, 0, 0, 0, KC, 2, 1);  // load X10
        vecs[13] = mk(1, 10, 31, 1, 0, 11, 1, 0, 0, 1, 1, 1, KH, 2, 1); // hold x3
        vecs[14] = mk(1, 10, 31, 1, 0, 11, 1, 0, 0, 1, 1, 1, KH, 2, 1);
        vecs[15] = mk(1, 10, 31, 1, 0, 11, 1, 0, 0, 1, 1, 1, KH, 2, 1);
        vecs[16] = mk(1, 10, 31, 1, 0, 11, 1, 0, 0, 0, 1, 1, KB, 3, 1); // release
        vecs[17] = mk(1, 10, 31, 1, 0, 11, 1, 0, 0, 0, 0, 0, KC, 3, 1);
        vecs[18] = mk(1, 1, 2, 1, 1, 12, 1, 0, 1, 1, 0, 0, KB, 3, 2);   // flush beats hold
        vecs[19] = mk(0, 3, 4, 1, 1, 13, 1, 1, 0, 0, 0, 0, KB, 3, 2);   // invalid ID
        vecs[20] = mk(1, 3, 4, 1, 1, 31, 1, 0, 0, 0, 0, 0, KC, 3, 2);   // Rd = X31

        repeat (2) @(posedge clk);
        #1;
        check("reset valid_EX", 64'(valid_EX), 64'd0);
        check("reset WriteRegister_EX", 64'(WriteRegister_EX), 64'd0);
        check("reset Da_EX", Da_EX, 64'd0);
        check("reset stall_cnt", 64'(stall_cnt), 64'd0);
        check("reset flush_cnt", 64'(flush_cnt), 64'd0);
        eValid = 0; eRw = 0; eMr = 0; eWr = 0; eAa = 0; eAb = 0;
        eDa = 0; eDb = 0; eImm = 0; eCtrl = 0;
        @(negedge clk);
        reset = 1'b1;
        step();

        for (int i = 0; i < 21; i++) begin
            setId(vecs[i].v, vecs[i].aa, vecs[i].ab, vecs[i].ua, vecs[i].ub, vecs[i].rd,
                  vecs[i].rw, vecs[i].mr, i);
            flush = vecs[i].fl;
            hold  = vecs[i].ho;
            #1;
            check($sformatf("v%0d load_use", i), 64'(load_use), 64'(vecs[i].expLu));
            check($sformatf("v%0d stall_pc", i), 64'(stall_pc), 64'(vecs[i].expStall));
            check($sformatf("v%0d stall_ifid", i), 64'(stall_ifid), 64'(vecs[i].expStall));
            if (vecs[i].kind == KB) begin
                eValid = 0; eRw = 0; eMr = 0; eWr = 31; eAa = 31; eAb = 31;
                eDa = 0; eDb = 0; eImm = 0; eCtrl = 0;
            end else if (vecs[i].kind == KC) begin
                eValid = 1; eRw = vecs[i].rw; eMr = vecs[i].mr; eWr = vecs[i].rd;
                eAa = vecs[i].aa; eAb = vecs[i].ab;
                eDa = 64'hA000_0000_0000_0000 | 64'(i);
                eDb = 64'hB000_0000_0000_0000 | 64'(i);
                eImm = 64'hC000_0000_0000_0000 | 64'(i);
                eCtrl = 12'h800 | 12'(i);
            end
            step();
            check($sformatf("v%0d valid_EX", i), 64'(valid_EX), 64'(eValid));
            check($sformatf("v%0d RegWrite_EX", i), 64'(RegWrite_EX), 64'(eRw));
            check($sformatf("v%0d MemRead_EX", i), 64'(MemRead_EX), 64'(eMr));
            check($sformatf("v%0d WriteRegister_EX", i), 64'(WriteRegister_EX), 64'(eWr));
            check($sformatf("v%0d Aa_EX", i), 64'(Aa_EX), 64'(eAa));
            check($sformatf("v%0d Ab_EX", i), 64'(Ab_EX), 64'(eAb));
            check($sformatf("v%0d Da_EX", i), Da_EX, eDa);
            check($sformatf("v%0d Db_EX", i), Db_EX, eDb);
            check($sformatf("v%0d imm_EX", i), imm_EX, eImm);
            check($sformatf("v%0d ctrl_EX", i), 64'(ctrl_EX), 64'(eCtrl));
            check($sformatf("v%0d stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].expStallCnt));
            check($sformatf("v%0d flush_cnt", i), 64'(flush_cnt), 64'(vecs[i].expFlushCnt));
        end
        flush = 1'b0;
        hold  = 1'b0;

        // Reset asserted while a load-use bubble sits in EX.
        setId(1, 1, 31, 1, 0, 2, 1, 1, 50);
        step();
        setId(1, 2, 4, 1, 1, 3, 1, 0, 51);
        #1;
        check("rst-seq load_use", 64'(load_use), 64'd1);
        step();
        check("rst-seq bubble valid_EX", 64'(valid_EX), 64'd0);
        check("rst-seq stall_cnt before reset", 64'(stall_cnt), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        check("async reset valid_EX", 64'(valid_EX), 64'd0);
        check("async reset WriteRegister_EX", 64'(WriteRegister_EX), 64'd0);
        check("async reset Aa_EX", 64'(Aa_EX), 64'd0);
        check("async reset stall_cnt", 64'(stall_cnt), 64'd0);
        check("async reset flush_cnt", 64'(flush_cnt), 64'd0);
        check("async reset small stall_cnt", 64'(sStallCnt), 64'd0);
        check("async reset stall_pc", 64'(stall_pc), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("post-reset capture valid_EX", 64'(valid_EX), 64'd1);
        check("post-reset capture Aa_EX", 64'(Aa_EX), 64'd2);
        check("post-reset capture Da_EX", Da_EX, 64'hA000_0000_0000_0033);

        // Twenty load-use stalls: 16-bit counter counts, 4-bit counter pins at 15.
        for (int k = 0; k < 20; k++) begin
            setId(1, 1, 31, 1, 0, 2, 1, 1, 100);
            step();
            setId(1, 2, 4, 1, 1, 3, 1, 0, 101);
            step();
            if (k == 14) begin
                check("small stall_cnt at 15", 64'(sStallCnt), 64'd15);
            end
        end
        check("stall_cnt after 20", 64'(stall_cnt), 64'd20);
        check("small stall_cnt saturated", 64'(sStallCnt), 64'd15);
        check("flush_cnt untouched by stalls", 64'(flush_cnt), 64'd0);

        flush = 1'b1;
        repeat (20) step();
        flush = 1'b0;
        check("flush_cnt after 20", 64'(flush_cnt), 64'd20);
        check("small flush_cnt saturated", 64'(sFlushCnt), 64'd15);
        check("stall_cnt untouched by flushes", 64'(stall_cnt), 64'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
